// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and the queued entry layout for the instruction prefetch queue.
package fetch_queue_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with flush; count disambiguates full from empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != FULL_CNT) || do_pop);
        head_d  = flush ? '0 : head_q + PW'(do_pop);
        tail_d  = flush ? '0 : tail_q + PW'(do_push);
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_q] <= din;
    end

    assign dout  = mem[head_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and ID.
// Owns the fetch PC, absorbs memory wait states and flushes on an EX redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic [XLEN-1:0]            iad,
    output logic                       ireq,
    input  logic [XLEN-1:0]            idt,
    input  logic                       acki_n,
    input  logic                       deq,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc4,
    output logic [XLEN-1:0]            out_ir,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic full, empty, push;
    entry_t head, tail_entry;

    // Redirect wins over any ack in the same cycle, so the stale word is dropped.
    always_comb begin
        ireq       = !full || deq;
        push       = ireq && !acki_n && !redirect;
        fetch_pc_d = redirect ? redirect_pc : (push ? fetch_pc_q + 32'd4 : fetch_pc_q);
        tail_entry = '{pc: fetch_pc_q, ir: idt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (tail_entry),
        .pop   (deq),
        .flush (redirect),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // An empty queue presents a NOP bubble to ID.
    always_comb begin
        iad       = fetch_pc_q;
        out_valid = !empty;
        out_pc    = out_valid ? head.pc : '0;
        out_ir    = out_valid ? head.ir : NOP_INSN;
        out_pc4   = out_pc + 32'd4;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench with a scoreboard of expected {pc, ir} head entries.
module tb_fetch_queue;
    import fetch_queue_pkg::*;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);

    logic clk = 1'b0, rst_n = 1'b0, redirect = 1'b0, acki_n = 1'b1, deq = 1'b0;
    logic ireq, out_valid;
    logic [31:0] redirect_pc = '0, iad, idt, out_pc, out_pc4, out_ir;
    logic [CW-1:0] count;
    int passed = 0, total = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;
    assign idt = 32'h0000_00A0 + iad;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .iad(iad), .ireq(ireq), .idt(idt), .acki_n(acki_n), .deq(deq),
        .out_valid(out_valid), .out_pc(out_pc), .out_pc4(out_pc4), .out_ir(out_ir),
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_state();
        logic [63:0] h;
        chk("iad", iad, exp_pc);
        chk("ireq", {31'b0, ireq}, {31'b0, (sb.size() < DEPTH) || deq});
        chk("count", 32'(count), 32'(sb.size()));
        chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            h = sb[0];
            chk("out_pc", out_pc, h[63:32]);
            chk("out_ir", out_ir, h[31:0]);
            chk("out_pc4", out_pc4, h[63:32] + 32'd4);
        end else begin
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_ir", out_ir, NOP_INSN);
            chk("empty_pc4", out_pc4, 32'h4);
        end
    endtask

    // One clock cycle: drive, check current state, advance the model, clock.
    task automatic cyc(input logic r, input logic [31:0] rpc, input logic a, input logic d);
        logic push, pop;
        redirect = r; redirect_pc = rpc; acki_n = a; deq = d;
        #1;
        check_state();
        push = ((sb.size() < DEPTH) || d) && !a && !r;
        pop  = d && (sb.size() != 0);
        if (r) begin
            sb.delete();
            exp_pc = rpc;
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back({exp_pc, 32'h0000_00A0 + exp_pc});
                exp_pc += 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("rst_iad", iad, 32'h0);
        chk("rst_ir", out_ir, 32'h0000_0013);
        rst_n = 1'b1;

        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("deq_empty_count", 32'(count), 32'h0);

        repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ireq", {31'b0, ireq}, 32'h0);
        chk("fill_iad", iad, 32'h10);
        chk("fill_pc", out_pc, 32'h0);
        chk("fill_ir", out_ir, 32'hA0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_hold_iad", iad, 32'h10);

        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        repeat (3) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            chk("wait_iad", iad, 32'h0);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wait_iad_after", iad, 32'h4);
        chk("wait_count", 32'(count), 32'd1);

        for (int i = 0; i < 8; i++) begin
            chk("stream_pc", out_pc, 32'(4 * i));
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("stream_count", 32'(count), 32'd1);

        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("refill_count", 32'(count), 32'd4);
        cyc(1'b1, 32'h100, 1'b0, 1'b1);
        chk("redir_count", 32'(count), 32'h0);
        chk("redir_valid", {31'b0, out_valid}, 32'h0);
        chk("redir_iad", iad, 32'h100);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_head_pc", out_pc, 32'h100);
        chk("redir_head_ir", out_ir, 32'h1A0);

        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full2_count", 32'(count), 32'd4);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("full_pushpop_count", 32'(count), 32'd4);
        chk("full_pushpop_pc", out_pc, 32'h104);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("pop_only_count", 32'(count), 32'd3);

        cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap_iad", iad, 32'h0);
        chk("wrap_pc4", out_pc4, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        acki_n = 1'b0; deq = 1'b0; redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_pc = 32'h0;
        chk("async_count", 32'(count), 32'h0);
        chk("async_iad", iad, 32'h0);
        check_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_state();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
